// File: rtl/mult_share_pkg.sv
// Shared definitions for the two-requester multiplier sharing controller:
// FSM state encodings, default widths and requester id constants.
package mult_share_pkg;

    localparam int OP_W_DEF = 6;
    localparam int P_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/mult_share_ctrl_core.sv
// mult_core: combinational signed OP_W x OP_W partial-product multiplier.
// Delivers the low P_W bits of the two's-complement product.
module mult_core #(
    parameter int OP_W = 6,
    parameter int P_W  = 10
) (
    input  logic signed [OP_W-1:0] a,
    input  logic signed [OP_W-1:0] b,
    output logic        [P_W-1:0]  p
);

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_pp;
    logic [P_W-1:0] w_sum;

    assign w_a_ext = P_W'(a);

    // The partial product of b's sign bit carries weight -2^(OP_W-1), so it is subtracted.
    always_comb begin
        w_sum = '0;
        w_pp  = '0;
        for (int i = 0; i < OP_W; i++) begin
            w_pp = b[i] ? (w_a_ext << i) : '0;
            if (i == OP_W - 1) begin
                w_sum = w_sum - w_pp;
            end else begin
                w_sum = w_sum + w_pp;
            end
        end
    end

    assign p = w_sum;

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one mult_core between two requesters: round-robin arbitration, operand
// registers, CALC_CYC settle cycles, valid/ready response. MULT_SHARE_FIXED_PRIO_EN selects fixed priority.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int OP_W     = OP_W_DEF,
    parameter int P_W      = P_W_DEF,
    parameter int CALC_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [OP_W-1:0] req0_a,
    input  logic [OP_W-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [OP_W-1:0] req1_a,
    input  logic [OP_W-1:0] req1_b,
    output logic            req1_ready,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [P_W-1:0]  rsp_p,
    input  logic            rsp_ready,
    output logic            busy
);

    localparam logic [3:0] CNT_LAST = 4'(CALC_CYC - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [OP_W-1:0] r_op_a;
    logic [OP_W-1:0] r_op_b;
    logic [3:0]      r_cnt;
    logic            r_rsp_id;
    logic [P_W-1:0]  r_rsp_p;
    logic [P_W-1:0]  w_core_p;
    logic            w_idle;
    logic            w_any_vld;
    logic            w_grant;
    logic            w_accept;
    logic            w_calc_done;
    logic            w_rsp_fire;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_any_vld   = req0_valid | req1_valid;
    assign w_accept    = w_idle & w_any_vld;
    assign w_calc_done = (r_state == ST_CALC) && (r_cnt == CNT_LAST);
    assign w_rsp_fire  = (r_state == ST_RESP) & rsp_ready;

`ifdef MULT_SHARE_FIXED_PRIO_EN
    assign w_grant = req0_valid ? REQ_ID0 : REQ_ID1;
`else
    logic r_last_grant;

    always_comb begin
        w_grant = REQ_ID0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = REQ_ID1;
        end
    end

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_ID1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign req0_ready = w_accept & (w_grant == REQ_ID0);
    assign req1_ready = w_accept & (w_grant == REQ_ID1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_CALC;
            ST_CALC: if (w_calc_done) w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_fire)  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_cnt    <= '0;
            r_rsp_id <= REQ_ID0;
            r_rsp_p  <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= (w_grant == REQ_ID1) ? req1_a : req0_a;
                r_op_b   <= (w_grant == REQ_ID1) ? req1_b : req0_b;
                r_rsp_id <= w_grant;
                r_cnt    <= '0;
            end else if ((r_state == ST_CALC) && !w_calc_done) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_calc_done) begin
                r_rsp_p <= w_core_p;
            end
        end
    end

    mult_core #(
        .OP_W (OP_W),
        .P_W  (P_W)
    ) u_mult_core (
        .a (r_op_a),
        .b (r_op_b),
        .p (w_core_p)
    );

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_p     = r_rsp_p;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: two instances (CALC_CYC=1 and 3) driven with directed and random
// operations, checked against a transaction-level model. Honours MULT_SHARE_FIXED_PRIO_EN.
module tb_mult_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n      [2];
    logic       req0_valid [2];
    logic [5:0] req0_a     [2];
    logic [5:0] req0_b     [2];
    logic       req0_ready [2];
    logic       req1_valid [2];
    logic [5:0] req1_a     [2];
    logic [5:0] req1_b     [2];
    logic       req1_ready [2];
    logic       rsp_valid  [2];
    logic       rsp_id     [2];
    logic [9:0] rsp_p      [2];
    logic       rsp_ready  [2];
    logic       busy       [2];

    int   n_checks = 0;
    int   n_errors = 0;
    logic m_last [2];

    always #5 clk = ~clk;

    mult_share_ctrl #(.OP_W(6), .P_W(10), .CALC_CYC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req0_valid(req0_valid[0]), .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req0_ready(req0_ready[0]),
        .req1_valid(req1_valid[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]), .req1_ready(req1_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_p(rsp_p[0]), .rsp_ready(rsp_ready[0]),
        .busy(busy[0])
    );

    mult_share_ctrl #(.OP_W(6), .P_W(10), .CALC_CYC(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req0_valid(req0_valid[1]), .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req0_ready(req0_ready[1]),
        .req1_valid(req1_valid[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]), .req1_ready(req1_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_p(rsp_p[1]), .rsp_ready(rsp_ready[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int calc_cyc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Low 10 bits of the true signed product.
    function automatic logic [9:0] golden(input logic [5:0] a, input logic [5:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[9:0];
    endfunction

    function automatic logic model_grant(input int d, input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~m_last[d];
`endif
        end
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic scramble(input int d);
        req0_a[d] = 6'($urandom);
        req0_b[d] = 6'($urandom);
        req1_a[d] = 6'($urandom);
        req1_b[d] = 6'($urandom);
    endtask

    // One operation starting in an IDLE cycle at a negedge; ends at the negedge after the handshake.
    task automatic run_op(input int d, input logic v0, input logic v1,
                          input logic [5:0] a0, input logic [5:0] b0,
                          input logic [5:0] a1, input logic [5:0] b1, input int hold);
        logic       g;
        logic [9:0] exp_p;
        int         k;
        req0_valid[d] = v0; req0_a[d] = a0; req0_b[d] = b0;
        req1_valid[d] = v1; req1_a[d] = a1; req1_b[d] = b1;
        rsp_ready[d]  = 1'b0;
        #1;
        g     = model_grant(d, v0, v1);
        exp_p = g ? golden(a1, b1) : golden(a0, b0);
        chk("ready0_idle", req0_ready[d], v0 && (g == 1'b0));
        chk("ready1_idle", req1_ready[d], v1 && (g == 1'b1));
        m_last[d] = g;
        @(posedge clk);
        @(negedge clk);
        scramble(d);
        k = 1;
        while (!rsp_valid[d] && k <= 40) begin
            chk("busy_calc", busy[d], 1'b1);
            chk("ready0_calc", req0_ready[d], 1'b0);
            chk("ready1_calc", req1_ready[d], 1'b0);
            @(negedge clk);
            scramble(d);
            k++;
        end
        chk("latency", k, 1 + calc_cyc(d));
        chk("rsp_id", rsp_id[d], g);
        chk("rsp_p", rsp_p[d], exp_p);
        repeat (hold) begin
            @(negedge clk);
            scramble(d);
            chk("hold_valid", rsp_valid[d], 1'b1);
            chk("hold_id", rsp_id[d], g);
            chk("hold_p", rsp_p[d], exp_p);
            chk("hold_busy", busy[d], 1'b1);
            chk("hold_ready0", req0_ready[d], 1'b0);
            chk("hold_ready1", req1_ready[d], 1'b0);
        end
        rsp_ready[d] = 1'b1;
        #1;
        chk("hs_ready0", req0_ready[d], 1'b0);
        chk("hs_ready1", req1_ready[d], 1'b0);
        @(negedge clk);
        rsp_ready[d]  = 1'b0;
        req0_valid[d] = 1'b0;
        req1_valid[d] = 1'b0;
        #1;
        chk("post_busy", busy[d], 1'b0);
        chk("post_valid", rsp_valid[d], 1'b0);
        @(negedge clk);
    endtask

    task automatic random_op(input int d);
        logic v0, v1;
        v0 = 1'($urandom);
        v1 = 1'($urandom);
        if (!v0 && !v1) v1 = 1'b1;
        run_op(d, v0, v1, 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
               int'($urandom_range(0, 3)));
    endtask

    // Accept a requester-1 op, then pulse reset while the op is still in CALC.
    task automatic reset_mid(input int d);
        req1_valid[d] = 1'b1; req1_a[d] = 6'd9; req1_b[d] = 6'd2;
        #1;
        chk("rst_pre_ready1", req1_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        req1_valid[d] = 1'b0;
        rst_n[d]      = 1'b0;
        #1;
        chk("rst_busy", busy[d], 1'b0);
        chk("rst_valid", rsp_valid[d], 1'b0);
        chk("rst_id", rsp_id[d], 1'b0);
        chk("rst_p", rsp_p[d], 10'd0);
        m_last[d] = 1'b1;
        @(negedge clk);
        rst_n[d] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid[d], 1'b0);
            chk("rst_idle", busy[d], 1'b0);
            chk("rst_no_ready", req0_ready[d] | req1_ready[d], 1'b0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; rsp_ready[d] = 1'b0;
            req0_valid[d] = 1'b0; req0_a[d] = '0; req0_b[d] = '0;
            req1_valid[d] = 1'b0; req1_a[d] = '0; req1_b[d] = '0;
            m_last[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", rsp_valid[d], 1'b0);
            chk("reset_busy", busy[d], 1'b0);
            chk("reset_id", rsp_id[d], 1'b0);
            chk("reset_p", rsp_p[d], 10'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        run_op(0, 1'b1, 1'b0, 6'd3, 6'd5, 6'd0, 6'd0, 0);
        run_op(0, 1'b1, 1'b1, 6'd7, 6'h3E, 6'd1, 6'h20, 0);
        run_op(0, 1'b1, 1'b1, 6'd7, 6'h3E, 6'd1, 6'h20, 0);
        repeat (6) run_op(0, 1'b1, 1'b1, 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 0);
        run_op(0, 1'b1, 1'b0, 6'h21, 6'h1F, 6'd0, 6'd0, 5);
        reset_mid(0);
        run_op(0, 1'b0, 1'b1, 6'd0, 6'd0, 6'h20, 6'h20, 1);
        repeat (30) random_op(0);

        run_op(1, 1'b1, 1'b0, 6'd11, 6'h3D, 6'd0, 6'd0, 2);
        run_op(1, 1'b1, 1'b1, 6'h25, 6'd4, 6'd6, 6'h3F, 0);
        repeat (15) random_op(1);
        reset_mid(1);
        run_op(1, 1'b1, 1'b1, 6'd3, 6'd5, 6'd2, 6'd2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
